voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of synth voices managed (2..16).
REQ-002 SHALL have parameter AGE_BITS, default 8, width of per-voice age counters.
REQ-003 SHALL have port clk  input  1  system clock (16 MHz); one clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ev_valid  input  1  decoded MIDI note event present.
REQ-006 SHALL have port ev_ready  output  1  allocator can accept an event.
REQ-007 SHALL have port ev_note_on  input  1  1 = note-on, 0 = note-off.
REQ-008 SHALL have port ev_note  input  7  MIDI note number.
REQ-009 SHALL have port ev_velocity  input  7  MIDI velocity.
REQ-010 SHALL have port voice_gate  output  NUM_VOICES  per-voice gate to envelope generators.
REQ-011 SHALL have port voice_trig  output  NUM_VOICES  per-voice one-cycle retrigger pulse.
REQ-012 SHALL have port voice_note  output  7*NUM_VOICES  per-voice note, voice i at bits [7i+6:7i].
REQ-013 SHALL have port voice_velocity  output  7*NUM_VOICES  per-voice velocity, same packing.
REQ-014 SHALL have port ev_dropped  output  1  one-cycle pulse: note-on discarded.

Function
REQ-015 SHALL accept an event on a rising edge where ev_valid and ev_ready are both 1; ev_note_on, ev_note, ev_velocity captured on that edge.
REQ-016 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE; ev_ready = 1 only in IDLE.
REQ-017 SHALL spend exactly NUM_VOICES cycles in SCAN, examining voice index 0..NUM_VOICES-1 one per cycle via a scan counter.
REQ-018 SHALL treat note-on with velocity 0 as note-off.
REQ-019 Note-on target priority: (a) voice with gate=1 and matching note (retrigger); (b) lowest-index voice with gate=0; (c) steal per REQ-031.
REQ-020 Note-off: SHALL clear gate of every voice with gate=1 and matching note; no match -> no state change, no pulse.
REQ-021 In COMMIT, a note-on SHALL set target gate=1, load note/velocity, zero target age, and drive voice_trig for that voice high for the next cycle only.
REQ-022 Outputs SHALL update on the COMMIT edge, i.e. NUM_VOICES+1 edges after acceptance; ev_ready SHALL be 1 in the cycle after COMMIT.
REQ-023 Age counters of gated voices SHALL increment by 1 on every accepted note-on (non-target voices), saturating at 2^AGE_BITS-1; no wrap.
REQ-024 Voices with gate=0 SHALL retain note, velocity and age.
REQ-025 Only one voice_trig bit SHALL be high in any cycle; ev_dropped and voice_trig SHALL never be high together.
REQ-026 ev_valid deasserted while not IDLE SHALL have no effect; event inputs need not be held after acceptance.

Reset
REQ-027 rst_n=0 SHALL asynchronously force FSM to IDLE, scan counter 0, all voice_gate/voice_trig/voice_note/voice_velocity/ages 0, ev_dropped 0.
REQ-028 Reset mid-SCAN or mid-COMMIT SHALL discard the in-flight event with no partial voice update.
REQ-029 ev_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro VOICE_ALLOCATOR_STEAL_EN SHALL select the full-allocation policy.
REQ-031 Defined: when no match and no free voice, SHALL steal voice with greatest age (ties -> lowest index), applied as REQ-021; ev_dropped never asserts.
REQ-032 Undefined: same condition SHALL leave all voices unchanged and pulse ev_dropped for one cycle after COMMIT; steal comparators absent.

Verification
REQ-033 Reset, then note-on 60 vel 100 -> after NUM_VOICES+1 edges voice 0 gate=1, note=60, vel=100, voice_trig=0001 for one cycle.
REQ-034 Note-on 60,62,64 then note-off 62 -> voice_gate=0101; note-off 70 -> no change, no pulse.
REQ-035 Note-on 60 twice -> second retriggers voice 0 only; voice_gate=0001, voice_trig=0001 again.
REQ-036 Five note-ons 60..64, NUM_VOICES=4: STEAL_EN -> voice 0 gets note 64, ev_dropped=0; no macro -> voices hold 60..63, ev_dropped pulses once.
REQ-037 Note-on 67 vel 0 while voice 2 holds 67 -> voice 2 gate cleared, no voice_trig.
REQ-038 Assert rst_n=0 during SCAN -> all outputs 0 immediately, ev_ready=1 after release, no voice allocated.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan of the voice table per MIDI event, commit on the final edge.
// Optional macro VOICE_ALLOCATOR_STEAL_EN enables stealing the oldest voice when the table is full.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_note_on,
    input  logic [6:0]                ev_note,
    input  logic [6:0]                ev_velocity,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_velocity,
    output logic                      ev_dropped
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0]       LAST_IDX = IW'(NUM_VOICES - 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = {AGE_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IW-1:0]           scan_cnt_r;
    logic                    ev_on_r;
    logic [6:0]              ev_note_r;
    logic [6:0]              ev_vel_r;
    logic                    accept_s;

    logic [NUM_VOICES-1:0]   gate_r;
    logic [NUM_VOICES-1:0]   trig_r;
    logic [6:0]              note_r [NUM_VOICES];
    logic [6:0]              vel_r  [NUM_VOICES];
    logic [AGE_BITS-1:0]     age_r  [NUM_VOICES];
    logic                    dropped_r;

    logic                    hit_found_r;
    logic [IW-1:0]           hit_idx_r;
    logic                    free_found_r;
    logic [IW-1:0]           free_idx_r;
    logic [NUM_VOICES-1:0]   off_mask_r;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic [IW-1:0]           steal_idx_r;
    logic [AGE_BITS-1:0]     steal_age_r;
`endif

    logic                    cur_match_s;
    logic                    cur_free_s;
    logic                    target_valid_s;
    logic [IW-1:0]           target_idx_s;

    function automatic logic [AGE_BITS-1:0] age_sat_inc(input logic [AGE_BITS-1:0] a);
        return (a == AGE_MAX) ? AGE_MAX : a + {{(AGE_BITS-1){1'b0}}, 1'b1};
    endfunction

    assign accept_s    = ev_valid && (state_r == ST_IDLE);
    assign ev_ready    = (state_r == ST_IDLE);
    assign cur_match_s = gate_r[scan_cnt_r] && (note_r[scan_cnt_r] == ev_note_r);
    assign cur_free_s  = !gate_r[scan_cnt_r];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   if (accept_s) state_nxt_s = ST_SCAN; else state_nxt_s = ST_IDLE;
            ST_SCAN:   if (scan_cnt_r == LAST_IDX) state_nxt_s = ST_COMMIT; else state_nxt_s = ST_SCAN;
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Event capture and per-cycle scan accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r   <= '0;
            ev_on_r      <= 1'b0;
            ev_note_r    <= 7'd0;
            ev_vel_r     <= 7'd0;
            hit_found_r  <= 1'b0;
            hit_idx_r    <= '0;
            free_found_r <= 1'b0;
            free_idx_r   <= '0;
            off_mask_r   <= '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            steal_idx_r  <= '0;
            steal_age_r  <= '0;
`endif
        end else if (accept_s) begin
            scan_cnt_r   <= '0;
            // Velocity 0 note-on is a note-off by MIDI convention.
            ev_on_r      <= ev_note_on && (ev_velocity != 7'd0);
            ev_note_r    <= ev_note;
            ev_vel_r     <= ev_velocity;
            hit_found_r  <= 1'b0;
            hit_idx_r    <= '0;
            free_found_r <= 1'b0;
            free_idx_r   <= '0;
            off_mask_r   <= '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            steal_idx_r  <= '0;
            steal_age_r  <= '0;
`endif
        end else if (state_r == ST_SCAN) begin
            scan_cnt_r <= (scan_cnt_r == LAST_IDX) ? '0 : scan_cnt_r + {{(IW-1){1'b0}}, 1'b1};
            if (cur_match_s && !hit_found_r) begin
                hit_found_r <= 1'b1;
                hit_idx_r   <= scan_cnt_r;
            end
            if (cur_free_s && !free_found_r) begin
                free_found_r <= 1'b1;
                free_idx_r   <= scan_cnt_r;
            end
            off_mask_r[scan_cnt_r] <= cur_match_s;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            // Strict compare keeps the lowest index on equal ages.
            if (age_r[scan_cnt_r] > steal_age_r) begin
                steal_idx_r <= scan_cnt_r;
                steal_age_r <= age_r[scan_cnt_r];
            end
`endif
        end
    end

    // Note-on target selection from the scan results
    always_comb begin
        target_valid_s = 1'b0;
        target_idx_s   = '0;
        if (hit_found_r) begin
            target_valid_s = 1'b1;
            target_idx_s   = hit_idx_r;
        end else if (free_found_r) begin
            target_valid_s = 1'b1;
            target_idx_s   = free_idx_r;
        end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
            target_valid_s = 1'b1;
            target_idx_s   = steal_idx_r;
`else
            target_valid_s = 1'b0;
            target_idx_s   = '0;
`endif
        end
    end

    // Voice table update on the commit edge; pulses last one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_r    <= '0;
            trig_r    <= '0;
            dropped_r <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= 7'd0;
                vel_r[i]  <= 7'd0;
                age_r[i]  <= '0;
            end
        end else begin
            trig_r    <= '0;
            dropped_r <= 1'b0;
            if (state_r == ST_COMMIT) begin
                if (ev_on_r) begin
                    if (target_valid_s) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IW'(i) == target_idx_s) begin
                                gate_r[i] <= 1'b1;
                                trig_r[i] <= 1'b1;
                                note_r[i] <= ev_note_r;
                                vel_r[i]  <= ev_vel_r;
                                age_r[i]  <= '0;
                            end else if (gate_r[i]) begin
                                age_r[i]  <= age_sat_inc(age_r[i]);
                            end
                        end
                    end else begin
                        dropped_r <= 1'b1;
                    end
                end else begin
                    gate_r <= gate_r & ~off_mask_r;
                end
            end
        end
    end

    assign voice_gate = gate_r;
    assign voice_trig = trig_r;
    assign ev_dropped = dropped_r;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7]     = note_r[g];
        assign voice_velocity[7*g +: 7] = vel_r[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (NUM_VOICES=4); expectations follow VOICE_ALLOCATOR_STEAL_EN.
module tb_voice_allocator;

    localparam int NV = 4;

    logic          clk;
    logic          rst_n;
    logic          ev_valid;
    logic          ev_ready;
    logic          ev_note_on;
    logic [6:0]    ev_note;
    logic [6:0]    ev_velocity;
    logic [NV-1:0] voice_gate;
    logic [NV-1:0] voice_trig;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_velocity;
    logic          ev_dropped;

    int n_checks;
    int n_fails;

    logic [NV-1:0] trig_seen;
    logic          drop_seen;

    voice_allocator #(.NUM_VOICES(NV), .AGE_BITS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_note_on     (ev_note_on),
        .ev_note        (ev_note),
        .ev_velocity    (ev_velocity),
        .voice_gate     (voice_gate),
        .voice_trig     (voice_trig),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .ev_dropped     (ev_dropped)
    );

    initial clk = 1'b0;
    always #31 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] note_of(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vel_of(input int i);
        return voice_velocity[7*i +: 7];
    endfunction

    // Pulses must be one-hot and mutually exclusive on every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("trig_onehot", 32'($countones(voice_trig) <= 1), 32'd1);
            check("trig_drop_excl", 32'(ev_dropped && (voice_trig != '0)), 32'd0);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gate", 32'(voice_gate), 32'd0);
        check("rst_trig", 32'(voice_trig), 32'd0);
        check("rst_note", 32'(voice_note), 32'd0);
        check("rst_vel", 32'(voice_velocity), 32'd0);
        check("rst_drop", 32'(ev_dropped), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(ev_ready), 32'd1);
    endtask

    task automatic do_event(input logic on, input logic [6:0] note, input logic [6:0] vel,
                            output logic [NV-1:0] trig_o, output logic drop_o);
        logic [NV-1:0] gate_before;
        @(negedge clk);
        check("ev_ready_idle", 32'(ev_ready), 32'd1);
        gate_before = voice_gate;
        ev_valid    = 1'b1;
        ev_note_on  = on;
        ev_note     = note;
        ev_velocity = vel;
        @(posedge clk);
        #1;
        ev_valid    = 1'b0;
        ev_note     = 7'd0;
        ev_velocity = 7'd0;
        check("ev_ready_busy", 32'(ev_ready), 32'd0);
        repeat (NV) @(posedge clk);
        #1;
        check("pre_commit_gate", 32'(voice_gate), 32'(gate_before));
        check("pre_commit_trig", 32'(voice_trig), 32'd0);
        @(posedge clk);
        #1;
        trig_o = voice_trig;
        drop_o = ev_dropped;
        check("post_commit_ready", 32'(ev_ready), 32'd1);
        @(posedge clk);
        #1;
        check("trig_one_cycle", 32'(voice_trig), 32'd0);
        check("drop_one_cycle", 32'(ev_dropped), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst_n       = 1'b0;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_note     = 7'd0;
        ev_velocity = 7'd0;

        // First note lands on voice 0
        apply_reset();
        do_event(1'b1, 7'd60, 7'd100, trig_seen, drop_seen);
        check("first_trig", 32'(trig_seen), 32'h1);
        check("first_gate", 32'(voice_gate), 32'h1);
        check("first_note", 32'(note_of(0)), 32'd60);
        check("first_vel", 32'(vel_of(0)), 32'd100);
        check("first_drop", 32'(drop_seen), 32'd0);

        // Same note retriggers voice 0 with the new velocity
        do_event(1'b1, 7'd60, 7'd90, trig_seen, drop_seen);
        check("retrig_trig", 32'(trig_seen), 32'h1);
        check("retrig_gate", 32'(voice_gate), 32'h1);
        check("retrig_vel", 32'(vel_of(0)), 32'd90);

        // Note-off clears only the matching voice; unknown note-off is inert
        apply_reset();
        do_event(1'b1, 7'd60, 7'd10, trig_seen, drop_seen);
        do_event(1'b1, 7'd62, 7'd20, trig_seen, drop_seen);
        check("alloc1_trig", 32'(trig_seen), 32'h2);
        do_event(1'b1, 7'd64, 7'd30, trig_seen, drop_seen);
        check("alloc2_trig", 32'(trig_seen), 32'h4);
        check("three_gate", 32'(voice_gate), 32'h7);
        do_event(1'b0, 7'd62, 7'd0, trig_seen, drop_seen);
        check("off62_gate", 32'(voice_gate), 32'h5);
        check("off62_trig", 32'(trig_seen), 32'h0);
        do_event(1'b0, 7'd70, 7'd0, trig_seen, drop_seen);
        check("off70_gate", 32'(voice_gate), 32'h5);
        check("off70_trig", 32'(trig_seen), 32'h0);
        check("off70_drop", 32'(drop_seen), 32'd0);
        check("off_keeps_note", 32'(note_of(1)), 32'd62);
        check("off_keeps_vel", 32'(vel_of(1)), 32'd20);
        do_event(1'b1, 7'd66, 7'd40, trig_seen, drop_seen);
        check("refill_trig", 32'(trig_seen), 32'h2);
        check("refill_note", 32'(note_of(1)), 32'd66);
        check("refill_gate", 32'(voice_gate), 32'h7);

        // Velocity-0 note-on releases voice 2
        apply_reset();
        do_event(1'b1, 7'd60, 7'd50, trig_seen, drop_seen);
        do_event(1'b1, 7'd61, 7'd50, trig_seen, drop_seen);
        do_event(1'b1, 7'd67, 7'd50, trig_seen, drop_seen);
        check("v2_note", 32'(note_of(2)), 32'd67);
        do_event(1'b1, 7'd67, 7'd0, trig_seen, drop_seen);
        check("vel0_gate", 32'(voice_gate), 32'h3);
        check("vel0_trig", 32'(trig_seen), 32'h0);
        check("vel0_drop", 32'(drop_seen), 32'd0);

        // Overflow: steal oldest or drop
        apply_reset();
        for (int k = 0; k < NV; k++) begin
            do_event(1'b1, 7'(60 + k), 7'd64, trig_seen, drop_seen);
            check("fill_trig", 32'(trig_seen), 32'(1 << k));
        end
        check("full_gate", 32'(voice_gate), 32'hF);
        do_event(1'b1, 7'd64, 7'd77, trig_seen, drop_seen);
`ifdef VOICE_ALLOCATOR_STEAL_EN
        check("steal_trig", 32'(trig_seen), 32'h1);
        check("steal_drop", 32'(drop_seen), 32'd0);
        check("steal_note", 32'(note_of(0)), 32'd64);
        check("steal_vel", 32'(vel_of(0)), 32'd77);
        check("steal_gate", 32'(voice_gate), 32'hF);
        // Ages now v0=0 v1=3 v2=2 v3=1, so voice 1 is next
        do_event(1'b1, 7'd65, 7'd78, trig_seen, drop_seen);
        check("steal2_trig", 32'(trig_seen), 32'h2);
        check("steal2_note", 32'(note_of(1)), 32'd65);
`else
        check("drop_trig", 32'(trig_seen), 32'h0);
        check("drop_pulse", 32'(drop_seen), 32'd1);
        check("drop_notes", 32'(voice_note), 32'({7'd63, 7'd62, 7'd61, 7'd60}));
        check("drop_gate", 32'(voice_gate), 32'hF);
        do_event(1'b1, 7'd65, 7'd78, trig_seen, drop_seen);
        check("drop2_pulse", 32'(drop_seen), 32'd1);
        check("drop2_notes", 32'(voice_note), 32'({7'd63, 7'd62, 7'd61, 7'd60}));
`endif

        // Reset during SCAN discards the event
        apply_reset();
        do_event(1'b1, 7'd61, 7'd33, trig_seen, drop_seen);
        check("pre_abort_gate", 32'(voice_gate), 32'h1);
        @(negedge clk);
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_note     = 7'd62;
        ev_velocity = 7'd44;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_gate", 32'(voice_gate), 32'd0);
        check("abort_note", 32'(voice_note), 32'd0);
        check("abort_vel", 32'(voice_velocity), 32'd0);
        check("abort_trig", 32'(voice_trig), 32'd0);
        check("abort_ready", 32'(ev_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_rel", 32'(ev_ready), 32'd1);
        repeat (NV + 3) @(posedge clk);
        #1;
        check("abort_no_alloc", 32'(voice_gate), 32'd0);
        check("abort_no_drop", 32'(ev_dropped), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
